bnn_sequencer: RTL and testbench

Controller placed in front of the tiny_bnn core. It serialises a byte-wide weight/threshold stream into the core's setup/param shift chain. It sequences each inference by presenting the 8-bit input vector as low and high nibbles through the bank-select pin, then captures the 8-bit core output behind a valid/ready handshake.

---
 rtl/bnn_sequencer.sv | 160 ++++++++++++++++
 tb/tb_bnn_sequencer.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bnn_sequencer.sv
// Front-end controller for the tiny_bnn core: serialises parameter bytes into the
// core's shift chain and sequences nibble-wise inferences behind valid/ready handshakes.
module bnn_sequencer #(
  parameter int PARAM_BITS    = 64,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cfg_valid,
  input  logic [7:0] cfg_data,
  output logic       cfg_ready,
  input  logic       infer_valid,
  input  logic [7:0] infer_x,
  output logic       infer_ready,
  output logic       res_valid,
  output logic [7:0] res_data,
  input  logic       res_ready,
  output logic       params_loaded,
  output logic       busy,
  output logic       bnn_setup,
  output logic       bnn_param,
  output logic       bnn_x_bank_hi,
  output logic [3:0] bnn_x_nib,
  input  logic [7:0] bnn_out
);

  localparam int CW = $clog2(PARAM_BITS) + 1;
  localparam int SW = $clog2(SETTLE_CYCLES) + 1;
  localparam logic [CW-1:0] LAST_BIT    = CW'(PARAM_BITS - 1);
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_SHIFT     = 3'd1;
  localparam logic [2:0] S_WAIT_BYTE = 3'd2;
  localparam logic [2:0] S_LO        = 3'd3;
  localparam logic [2:0] S_HI        = 3'd4;
  localparam logic [2:0] S_SETTLE    = 3'd5;
  localparam logic [2:0] S_RESULT    = 3'd6;

  logic [2:0]    state_q, state_d;
  logic [CW-1:0] bitcnt_q, bitcnt_d;
  logic [SW-1:0] settle_q, settle_d;
  logic          loaded_q, loaded_d;
  logic [7:0]    res_q, res_d;
  logic [7:0]    shift_q;
  logic [7:0]    x_q;
  logic          shift_ld, shift_en, x_ld;
  logic          byte_end, last_bit;

  assign byte_end      = (bitcnt_q[2:0] == 3'd7);
  assign last_bit      = (bitcnt_q == LAST_BIT);
  assign busy          = (state_q != S_IDLE);
  assign params_loaded = loaded_q;
  assign res_data      = res_q;

  always_comb begin
    state_d       = state_q;
    bitcnt_d      = bitcnt_q;
    settle_d      = settle_q;
    loaded_d      = loaded_q;
    res_d         = res_q;
    shift_ld      = 1'b0;
    shift_en      = 1'b0;
    x_ld          = 1'b0;
    cfg_ready     = 1'b0;
    infer_ready   = 1'b0;
    res_valid     = 1'b0;
    bnn_setup     = 1'b0;
    bnn_param     = 1'b0;
    bnn_x_bank_hi = 1'b0;
    bnn_x_nib     = 4'd0;
    case (state_q)
      S_IDLE: begin
        cfg_ready   = 1'b1;
        // A pending parameter load always takes priority over an inference.
        infer_ready = loaded_q & ~cfg_valid;
        if (cfg_valid) begin
          loaded_d = 1'b0;
          bitcnt_d = '0;
          shift_ld = 1'b1;
          state_d  = S_SHIFT;
        end else if (infer_valid && loaded_q) begin
          x_ld    = 1'b1;
          state_d = S_LO;
        end
      end
      S_SHIFT: begin
        bnn_setup = 1'b1;
        bnn_param = shift_q[0];
        bitcnt_d  = bitcnt_q + CW'(1);
        cfg_ready = byte_end & ~last_bit;
        if (last_bit) begin
          loaded_d = 1'b1;
          state_d  = S_IDLE;
        end else if (byte_end) begin
          if (cfg_valid) shift_ld = 1'b1;
          else           state_d  = S_WAIT_BYTE;
        end else begin
          shift_en = 1'b1;
        end
      end
      S_WAIT_BYTE: begin
        cfg_ready = 1'b1;
        if (cfg_valid) begin
          shift_ld = 1'b1;
          state_d  = S_SHIFT;
        end
      end
      S_LO: begin
        bnn_x_nib = x_q[3:0];
        state_d   = S_HI;
      end
      S_HI: begin
        bnn_x_bank_hi = 1'b1;
        bnn_x_nib     = x_q[7:4];
        settle_d      = '0;
        state_d       = S_SETTLE;
      end
      S_SETTLE: begin
        bnn_x_bank_hi = 1'b1;
        bnn_x_nib     = x_q[7:4];
        if (settle_q == SETTLE_LAST) begin
          res_d   = bnn_out;
          state_d = S_RESULT;
        end else begin
          settle_d = settle_q + SW'(1);
        end
      end
      S_RESULT: begin
        res_valid = 1'b1;
        if (res_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      bitcnt_q <= '0;
      settle_q <= '0;
      loaded_q <= 1'b0;
      res_q    <= 8'd0;
    end else begin
      state_q  <= state_d;
      bitcnt_q <= bitcnt_d;
      settle_q <= settle_d;
      loaded_q <= loaded_d;
      res_q    <= res_d;
    end
  end

  // Datapath registers are only observed through state-gated outputs, so they carry no reset.
  always_ff @(posedge clk) begin
    if (shift_ld)      shift_q <= cfg_data;
    else if (shift_en) shift_q <= {1'b0, shift_q[7:1]};
    if (x_ld) x_q <= infer_x;
  end

endmodule

// File: tb/tb_bnn_sequencer.sv
// Randomised bench for bnn_sequencer with a behavioural core model and load/inference scoreboard.
module tb_bnn_sequencer;
  localparam int PB = 64;
  localparam int S  = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cfg_valid = 1'b0;
  logic [7:0] cfg_data = 8'd0;
  logic       cfg_ready;
  logic       infer_valid = 1'b0;
  logic [7:0] infer_x = 8'd0;
  logic       infer_ready;
  logic       res_valid;
  logic [7:0] res_data;
  logic       res_ready = 1'b0;
  logic       params_loaded, busy, bnn_setup, bnn_param, bnn_x_bank_hi;
  logic [3:0] bnn_x_nib;
  logic [7:0] bnn_out;

  bnn_sequencer #(.PARAM_BITS(PB), .SETTLE_CYCLES(S)) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_valid(cfg_valid), .cfg_data(cfg_data), .cfg_ready(cfg_ready),
    .infer_valid(infer_valid), .infer_x(infer_x), .infer_ready(infer_ready),
    .res_valid(res_valid), .res_data(res_data), .res_ready(res_ready),
    .params_loaded(params_loaded), .busy(busy),
    .bnn_setup(bnn_setup), .bnn_param(bnn_param),
    .bnn_x_bank_hi(bnn_x_bank_hi), .bnn_x_nib(bnn_x_nib), .bnn_out(bnn_out)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Core model: parameter chain plus per-bank input latches.
  logic [PB-1:0] chain = '0;
  logic [3:0]    lo_r = 4'd0, hi_r = 4'd0;
  logic          ovr_en = 1'b0;
  logic [7:0]    ovr_val = 8'd0;
  always @(posedge clk) begin
    if (bnn_setup) chain <= {bnn_param, chain[PB-1:1]};
    if (bnn_x_bank_hi) hi_r <= bnn_x_nib;
    else               lo_r <= bnn_x_nib;
  end
  assign bnn_out = ovr_en ? ovr_val : ({hi_r, lo_r} ^ chain[7:0] ^ chain[PB-1:PB-8]);

  // Load monitor: collects shifted bits and setup-high timing between clears.
  int          clr_req = 0, clr_ack = 0;
  logic [63:0] obs_word;
  int obs_n, setup_cnt, run, maxrun, last_setup_cyc, pl_cyc;
  bit pl_seen;
  always @(negedge clk) begin
    if (clr_req != clr_ack) begin
      clr_ack = clr_req; obs_word = '0; obs_n = 0; setup_cnt = 0;
      run = 0; maxrun = 0; last_setup_cyc = 0; pl_cyc = 0; pl_seen = 0;
    end
    if (bnn_setup) begin
      if (obs_n < 64) obs_word[obs_n] = bnn_param;
      obs_n++; setup_cnt++; run++;
      if (run > maxrun) maxrun = run;
      last_setup_cyc = cyc;
    end else begin
      run = 0;
    end
    if (params_loaded && !pl_seen && setup_cnt > 0) begin
      pl_seen = 1; pl_cyc = cyc;
    end
  end

  logic [7:0] ld [8];
  logic [7:0] cur [8];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int pre);
    int n;
    repeat (pre) tick();
    cfg_valid = 1'b1; cfg_data = b; n = 0;
    @(negedge clk);
    while (!cfg_ready && n < 40) begin @(negedge clk); n++; end
    if (!cfg_ready) check_eq("cfg_ready_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
    cfg_valid = 1'b0; cfg_data = 8'($urandom);
  endtask

  // gap_mode: 0 = gapless expected, 1 = explicit gap after byte gap_idx, 2 = random spacing
  task automatic do_load(input int first_i, input int gap_idx, input int gap_len, input int gap_mode);
    logic [63:0] exp_word;
    int n;
    if (first_i == 0) clr_req++;
    for (int i = first_i; i < 8; i++) begin
      send_byte(ld[i], (gap_mode == 2) ? int'($urandom_range(0, 10)) : 0);
      if (i == gap_idx) begin
        repeat (8) @(posedge clk);
        @(negedge clk);
        check_eq("gap_setup", bnn_setup, 0);
        check_eq("gap_cfg_ready", cfg_ready, 1);
        repeat (gap_len - 1) @(posedge clk);
        #1;
      end
    end
    n = 0;
    @(negedge clk);
    while (!params_loaded && n < 30) begin @(negedge clk); n++; end
    check_eq("loaded", params_loaded, 1);
    tick();
    for (int i = 0; i < 8; i++) exp_word[8*i +: 8] = ld[i];
    check_eq("setup_cycles", setup_cnt, PB);
    check_eq("chain_bits", obs_word, exp_word);
    check_eq("loaded_latency", pl_cyc - last_setup_cyc, 1);
    if (gap_mode == 0) check_eq("gapless_run", maxrun, PB);
    if (gap_mode == 1) check_eq("gap_run_split", maxrun < PB, 1);
    for (int i = 0; i < 8; i++) cur[i] = ld[i];
  endtask

  task automatic infer(input logic [7:0] x, input int hold);
    logic [7:0] exp;
    exp = ovr_en ? ovr_val : (x ^ cur[0] ^ cur[7]);
    infer_valid = 1'b1; infer_x = x;
    @(negedge clk);
    check_eq("infer_ready", infer_ready, 1);
    @(posedge clk); #1;
    infer_valid = 1'b0; infer_x = 8'($urandom);
    @(negedge clk);
    check_eq("lo_phase", {bnn_x_bank_hi, bnn_x_nib}, {1'b0, x[3:0]});
    check_eq("busy", busy, 1);
    repeat (1 + S) begin
      @(negedge clk);
      check_eq("hi_phase", {bnn_x_bank_hi, bnn_x_nib}, {1'b1, x[7:4]});
      check_eq("res_early", res_valid, 0);
    end
    @(negedge clk);
    check_eq("res_valid", res_valid, 1);
    check_eq("res_data", res_data, exp);
    check_eq("nib_idle", {bnn_x_bank_hi, bnn_x_nib}, 0);
    repeat (hold) begin
      tick();
      @(negedge clk);
      check_eq("res_hold_valid", res_valid, 1);
      check_eq("res_hold_data", res_data, exp);
    end
    tick(); res_ready = 1'b1;
    @(negedge clk);
    check_eq("res_hs_valid", res_valid, 1);
    tick(); res_ready = 1'b0;
    @(negedge clk);
    check_eq("res_done", res_valid, 0);
    check_eq("idle_busy", busy, 0);
    tick();
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check_eq("rst_cfg_ready", cfg_ready, 1);
    check_eq("rst_outs", {infer_ready, busy, res_valid, res_data, params_loaded,
                          bnn_setup, bnn_param, bnn_x_bank_hi, bnn_x_nib}, 0);

    // Inference refused while nothing is loaded
    infer_valid = 1'b1; infer_x = 8'h55;
    repeat (3) begin
      @(negedge clk);
      check_eq("unloaded_infer_ready", infer_ready, 0);
      check_eq("unloaded_busy", busy, 0);
    end
    tick(); infer_valid = 1'b0;

    for (int i = 0; i < 8; i++) ld[i] = 8'hA5;
    do_load(0, -1, 0, 0);

    ovr_en = 1'b1; ovr_val = 8'h81;
    infer(8'h3C, 4);
    ovr_en = 1'b0;

    for (int i = 0; i < 8; i++) ld[i] = 8'($urandom);
    do_load(0, 1, 3, 1);
    infer(8'($urandom), 1);

    // cfg and infer together in IDLE: cfg wins
    for (int i = 0; i < 8; i++) ld[i] = 8'($urandom);
    clr_req++;
    cfg_valid = 1'b1; cfg_data = ld[0]; infer_valid = 1'b1; infer_x = 8'h99;
    @(negedge clk);
    check_eq("collide_infer_ready", infer_ready, 0);
    check_eq("collide_cfg_ready", cfg_ready, 1);
    tick(); cfg_valid = 1'b0; infer_valid = 1'b0;
    @(negedge clk);
    check_eq("collide_shift", {busy, bnn_setup, params_loaded}, 3'b110);
    tick();
    do_load(1, -1, 0, 3);
    infer(8'($urandom), 0);

    // Asynchronous reset mid-load
    for (int i = 0; i < 8; i++) ld[i] = 8'($urandom);
    clr_req++;
    for (int i = 0; i < 3; i++) send_byte(ld[i], 0);
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_eq("arst_cfg_ready", cfg_ready, 1);
    check_eq("arst_outs", {infer_ready, busy, res_valid, res_data, params_loaded,
                           bnn_setup, bnn_param, bnn_x_bank_hi, bnn_x_nib}, 0);
    tick(); rst_n = 1'b1;
    infer_valid = 1'b1; infer_x = 8'h12;
    repeat (3) begin
      @(negedge clk);
      check_eq("post_rst_infer_ready", infer_ready, 0);
    end
    tick(); infer_valid = 1'b0;
    do_load(0, -1, 0, 0);
    infer(8'($urandom), 2);

    repeat (3) begin
      for (int i = 0; i < 8; i++) ld[i] = 8'($urandom);
      do_load(0, -1, 0, 2);
      repeat (3) infer(8'($urandom), int'($urandom_range(0, 3)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
endmodule
